// File: rtl/sys_result_broadcaster.sv
// Result broadcaster: buffers GPR/SPR/CR results in per-channel FIFOs and
// drives the operand-update buses on grant. Optional: SYS_BCAST_BYPASS_EN.

module sys_bcast_channel #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         req,
  input  logic         grant,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          push, pop, bypass, fifo_wr;

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    in_ready    = (count_q < CW'(DEPTH)) & rst_n;
    push        = in_valid & in_ready;
    pop         = (count_q != '0) & grant;
`ifdef SYS_BCAST_BYPASS_EN
    bypass      = (count_q == '0) & grant & push;
    req         = (count_q != '0) | push;
`else
    bypass      = 1'b0;
    req         = (count_q != '0);
`endif
    fifo_wr     = push & ~bypass;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = pop | bypass;
    out_data_d  = out_data_q;

    if (fifo_wr) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);

    if (fifo_wr && !pop)      count_d = count_q + CW'(1);
    else if (!fifo_wr && pop) count_d = count_q - CW'(1);

    if (pop)         out_data_d = mem_q[rd_ptr_q];
    else if (bypass) out_data_d = in_data;
  end

  // NOTE: state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // NOTE: storage is not reset; count_q gates every read, so stale data is never visible.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= in_data;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
endmodule

module sys_result_broadcaster #(
  parameter int RS_ID_WIDTH = 5,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        gpr_output_valid,
  output logic                        gpr_output_ready,
  input  logic [RS_ID_WIDTH-1:0]      gpr_rs_id_out,
  input  logic [4:0]                  gpr_result_reg_addr_out,
  input  logic [31:0]                 gpr_result,
  input  logic                        spr_output_valid,
  output logic                        spr_output_ready,
  input  logic [RS_ID_WIDTH-1:0]      spr_rs_id_out,
  input  logic [9:0]                  spr_result_reg_addr_out,
  input  logic [31:0]                 spr_result,
  input  logic                        cr_output_valid,
  output logic                        cr_output_ready,
  input  logic [RS_ID_WIDTH-1:0]      cr_rs_id_out,
  input  logic [0:7]                  cr_result_enable,
  input  logic [0:31]                 cr_result,
  output logic                        gpr_bcast_req,
  output logic                        spr_bcast_req,
  output logic                        cr_bcast_req,
  input  logic                        gpr_bcast_grant,
  input  logic                        spr_bcast_grant,
  input  logic                        cr_bcast_grant,
  output logic                        update_gpr_op_valid,
  output logic [RS_ID_WIDTH-1:0]      update_gpr_op_rs_id_in,
  output logic [31:0]                 update_gpr_op_value_in,
  output logic [4:0]                  update_gpr_reg_addr,
  output logic                        update_spr_op_valid,
  output logic [RS_ID_WIDTH-1:0]      update_spr_op_rs_id_in,
  output logic [31:0]                 update_spr_op_value_in,
  output logic [9:0]                  update_spr_reg_addr,
  output logic [0:7]                  update_cr_op_valid,
  output logic [0:7][RS_ID_WIDTH-1:0] update_cr_op_rs_id_in,
  output logic [0:7][3:0]             update_cr_op_value_in
);
  localparam int W_GPR = RS_ID_WIDTH + 5 + 32;
  localparam int W_SPR = RS_ID_WIDTH + 10 + 32;
  localparam int W_CR  = RS_ID_WIDTH + 8 + 32;

  logic [W_GPR-1:0]       gpr_bcast_data;
  logic [W_SPR-1:0]       spr_bcast_data;
  logic [W_CR-1:0]        cr_bcast_data;
  logic                   cr_bcast_valid;
  logic [RS_ID_WIDTH-1:0] cr_id_s;
  logic [0:7]             cr_en_s;
  logic [0:31]            cr_val_s;

  sys_bcast_channel #(.W(W_GPR), .DEPTH(FIFO_DEPTH)) u_gpr (
    .clk      (clk),
    .rst_n    (rst),
    .in_valid (gpr_output_valid),
    .in_data  ({gpr_rs_id_out, gpr_result_reg_addr_out, gpr_result}),
    .in_ready (gpr_output_ready),
    .req      (gpr_bcast_req),
    .grant    (gpr_bcast_grant),
    .out_valid(update_gpr_op_valid),
    .out_data (gpr_bcast_data)
  );

  sys_bcast_channel #(.W(W_SPR), .DEPTH(FIFO_DEPTH)) u_spr (
    .clk      (clk),
    .rst_n    (rst),
    .in_valid (spr_output_valid),
    .in_data  ({spr_rs_id_out, spr_result_reg_addr_out, spr_result}),
    .in_ready (spr_output_ready),
    .req      (spr_bcast_req),
    .grant    (spr_bcast_grant),
    .out_valid(update_spr_op_valid),
    .out_data (spr_bcast_data)
  );

  sys_bcast_channel #(.W(W_CR), .DEPTH(FIFO_DEPTH)) u_cr (
    .clk      (clk),
    .rst_n    (rst),
    .in_valid (cr_output_valid),
    .in_data  ({cr_rs_id_out, cr_result_enable, cr_result}),
    .in_ready (cr_output_ready),
    .req      (cr_bcast_req),
    .grant    (cr_bcast_grant),
    .out_valid(cr_bcast_valid),
    .out_data (cr_bcast_data)
  );

  assign {update_gpr_op_rs_id_in, update_gpr_reg_addr, update_gpr_op_value_in} = gpr_bcast_data;
  assign {update_spr_op_rs_id_in, update_spr_reg_addr, update_spr_op_value_in} = spr_bcast_data;
  assign {cr_id_s, cr_en_s, cr_val_s} = cr_bcast_data;

  // CR field i is big-endian nibble [4i:4i+3]; a field strobes only if enabled.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      update_cr_op_valid[i]    = cr_bcast_valid & cr_en_s[i];
      update_cr_op_rs_id_in[i] = cr_id_s;
      update_cr_op_value_in[i] = cr_val_s[4*i +: 4];
    end
  end
endmodule

// File: tb/tb_sys_result_broadcaster.sv
// Self-checking bench for sys_result_broadcaster: directed tables and sequences
// plus randomized traffic against a queue-based per-channel reference model.

module tb_sys_result_broadcaster;
  localparam int RW = 5;
  localparam int D  = 2;
`ifdef SYS_BCAST_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int LAT = BYP ? 1 : 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic gpr_output_valid = 0, spr_output_valid = 0, cr_output_valid = 0;
  logic gpr_output_ready, spr_output_ready, cr_output_ready;
  logic [RW-1:0] gpr_rs_id_out = 0, spr_rs_id_out = 0, cr_rs_id_out = 0;
  logic [4:0]  gpr_result_reg_addr_out = 0;
  logic [31:0] gpr_result = 0;
  logic [9:0]  spr_result_reg_addr_out = 0;
  logic [31:0] spr_result = 0;
  logic [0:7]  cr_result_enable = 0;
  logic [0:31] cr_result = 0;
  logic gpr_bcast_req, spr_bcast_req, cr_bcast_req;
  logic gpr_bcast_grant = 0, spr_bcast_grant = 0, cr_bcast_grant = 0;
  logic update_gpr_op_valid, update_spr_op_valid;
  logic [RW-1:0] update_gpr_op_rs_id_in, update_spr_op_rs_id_in;
  logic [31:0] update_gpr_op_value_in, update_spr_op_value_in;
  logic [4:0]  update_gpr_reg_addr;
  logic [9:0]  update_spr_reg_addr;
  logic [0:7]  update_cr_op_valid;
  logic [0:7][RW-1:0] update_cr_op_rs_id_in;
  logic [0:7][3:0]    update_cr_op_value_in;

  int tests = 0;
  int failed = 0;

  sys_result_broadcaster #(.RS_ID_WIDTH(RW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .gpr_output_valid(gpr_output_valid), .gpr_output_ready(gpr_output_ready),
    .gpr_rs_id_out(gpr_rs_id_out), .gpr_result_reg_addr_out(gpr_result_reg_addr_out),
    .gpr_result(gpr_result),
    .spr_output_valid(spr_output_valid), .spr_output_ready(spr_output_ready),
    .spr_rs_id_out(spr_rs_id_out), .spr_result_reg_addr_out(spr_result_reg_addr_out),
    .spr_result(spr_result),
    .cr_output_valid(cr_output_valid), .cr_output_ready(cr_output_ready),
    .cr_rs_id_out(cr_rs_id_out), .cr_result_enable(cr_result_enable), .cr_result(cr_result),
    .gpr_bcast_req(gpr_bcast_req), .spr_bcast_req(spr_bcast_req), .cr_bcast_req(cr_bcast_req),
    .gpr_bcast_grant(gpr_bcast_grant), .spr_bcast_grant(spr_bcast_grant),
    .cr_bcast_grant(cr_bcast_grant),
    .update_gpr_op_valid(update_gpr_op_valid), .update_gpr_op_rs_id_in(update_gpr_op_rs_id_in),
    .update_gpr_op_value_in(update_gpr_op_value_in), .update_gpr_reg_addr(update_gpr_reg_addr),
    .update_spr_op_valid(update_spr_op_valid), .update_spr_op_rs_id_in(update_spr_op_rs_id_in),
    .update_spr_op_value_in(update_spr_op_value_in), .update_spr_reg_addr(update_spr_reg_addr),
    .update_cr_op_valid(update_cr_op_valid), .update_cr_op_rs_id_in(update_cr_op_rs_id_in),
    .update_cr_op_value_in(update_cr_op_value_in)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [RW-1:0] id;
    logic [9:0]    addr;
    logic [0:7]    en;
    logic [31:0]   val;
  } ent_t;

  // Reference model: one queue per channel plus the broadcast register contents.
  ent_t mq [3][$];
  logic bv [3];
  ent_t bd [3];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 3; c++) begin
      mq[c].delete();
      bv[c] = 1'b0;
      bd[c] = '0;
    end
  endtask

  // One clock: check ready/req, advance the model, then check broadcast outputs.
  task automatic cycle();
    logic vld [3], rdy [3], rq [3], gnt [3], nbv [3];
    ent_t in [3], nbd [3];
    logic [0:7] ev;
    bit exp_rdy, push, by, pop;
    #1;
    vld = '{gpr_output_valid, spr_output_valid, cr_output_valid};
    rdy = '{gpr_output_ready, spr_output_ready, cr_output_ready};
    rq  = '{gpr_bcast_req, spr_bcast_req, cr_bcast_req};
    gnt = '{gpr_bcast_grant, spr_bcast_grant, cr_bcast_grant};
    in[0] = '{id: gpr_rs_id_out, addr: 10'(gpr_result_reg_addr_out), en: 8'h00, val: gpr_result};
    in[1] = '{id: spr_rs_id_out, addr: spr_result_reg_addr_out, en: 8'h00, val: spr_result};
    in[2] = '{id: cr_rs_id_out, addr: 10'h000, en: cr_result_enable, val: cr_result};
    for (int c = 0; c < 3; c++) begin
      exp_rdy = mq[c].size() < D;
      check($sformatf("ready_ch%0d", c), 64'(rdy[c]), 64'(exp_rdy));
      push = vld[c] && exp_rdy;
      by   = BYP && mq[c].size() == 0 && gnt[c] && push;
      check($sformatf("req_ch%0d", c), 64'(rq[c]), 64'(mq[c].size() != 0 || (BYP && push)));
      pop  = mq[c].size() != 0 && gnt[c];
      nbv[c] = pop || by;
      nbd[c] = bd[c];
      if (pop) nbd[c] = mq[c].pop_front();
      else if (by) nbd[c] = in[c];
      if (push && !by) mq[c].push_back(in[c]);
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      bv[c] = nbv[c];
      bd[c] = nbd[c];
    end
    check("gpr_bcast",
          64'({update_gpr_op_valid, update_gpr_op_rs_id_in, update_gpr_reg_addr, update_gpr_op_value_in}),
          64'({bv[0], bd[0].id, bd[0].addr[4:0], bd[0].val}));
    check("spr_bcast",
          64'({update_spr_op_valid, update_spr_op_rs_id_in, update_spr_reg_addr, update_spr_op_value_in}),
          64'({bv[1], bd[1].id, bd[1].addr, bd[1].val}));
    for (int i = 0; i < 8; i++) ev[i] = bv[2] & bd[2].en[i];
    check("cr_strobe", 64'(update_cr_op_valid), 64'(ev));
    check("cr_value", 64'(update_cr_op_value_in), 64'(bd[2].val));
    check("cr_id", 64'(update_cr_op_rs_id_in), 64'({8{bd[2].id}}));
  endtask

  task automatic apply_reset(input int n, input logic vld);
    rst = 1'b0;
    gpr_output_valid = vld; spr_output_valid = vld; cr_output_valid = vld;
    gpr_bcast_grant = 1; spr_bcast_grant = 1; cr_bcast_grant = 1;
    model_clear();
    repeat (n) begin
      @(posedge clk);
      #1;
      check("rst_ready", 64'({gpr_output_ready, spr_output_ready, cr_output_ready}), 64'(0));
      check("rst_req", 64'({gpr_bcast_req, spr_bcast_req, cr_bcast_req}), 64'(0));
      check("rst_strobe", 64'({update_gpr_op_valid, update_spr_op_valid, update_cr_op_valid}), 64'(0));
      check("rst_gpr_data", 64'({update_gpr_op_rs_id_in, update_gpr_reg_addr, update_gpr_op_value_in}), 64'(0));
      check("rst_spr_data", 64'({update_spr_op_rs_id_in, update_spr_reg_addr, update_spr_op_value_in}), 64'(0));
      check("rst_cr_data", 64'({update_cr_op_rs_id_in, update_cr_op_value_in}), 64'(0));
    end
    gpr_output_valid = 0; spr_output_valid = 0; cr_output_valid = 0;
    rst = 1'b1;
    #1;
    check("post_rst_ready", 64'({gpr_output_ready, spr_output_ready, cr_output_ready}), 64'(3'b111));
  endtask

  typedef struct {
    logic [0:31]   cr;
    logic [0:7]    en;
    logic [RW-1:0] id;
    logic [0:7]    ev;
    logic [31:0]   evals;
  } crv_t;

  initial begin
    crv_t tbl [4];
    bit   bp_rdy [7];
    logic [32:0] bp_out [7];
    logic [31:0] sv [3];
    logic [31:0] gv [10];
    logic [31:0] obs [$];
    int idx, t_g, t_s, t_c, cyc;
    bit acc;

    tbl[0] = '{cr: 32'h12345678, en: 8'b10100001, id: 5'd9,  ev: 8'b10100001, evals: 32'h12345678};
    tbl[1] = '{cr: 32'hCAFEF00D, en: 8'b11111111, id: 5'd31, ev: 8'b11111111, evals: 32'hCAFEF00D};
    tbl[2] = '{cr: 32'h0F0F0F0F, en: 8'b00000000, id: 5'd3,  ev: 8'b00000000, evals: 32'h0F0F0F0F};
    tbl[3] = '{cr: 32'h87654321, en: 8'b01000010, id: 5'd0,  ev: 8'b01000010, evals: 32'h87654321};

    // Reset held 3 cycles with every input valid.
    gpr_result = 32'h11111111; spr_result = 32'h22222222; cr_result = 32'h33333333;
    cr_result_enable = 8'hFF;
    apply_reset(3, 1'b1);

    // Single GPR result with grant tied high.
    gpr_output_valid = 1; gpr_rs_id_out = 5; gpr_result_reg_addr_out = 3; gpr_result = 32'hDEADBEEF;
    for (int k = 1; k <= 3; k++) begin
      cycle();
      if (k == 1) gpr_output_valid = 0;
      check("gpr_single_valid", 64'(update_gpr_op_valid), 64'(k == LAT));
      if (k == LAT)
        check("gpr_single_data",
              64'({update_gpr_op_rs_id_in, update_gpr_reg_addr, update_gpr_op_value_in}),
              64'({5'd5, 5'd3, 32'hDEADBEEF}));
    end

    // SPR backpressure: three pushes against a 2-deep FIFO with grant low.
    sv = '{32'hA0000001, 32'hA0000002, 32'hA0000003};
    bp_rdy = '{1, 1, 0, 0, 0, 1, 1};
    bp_out = '{33'h0, 33'h0, 33'h0, 33'h0,
               {1'b1, 32'hA0000001}, {1'b1, 32'hA0000002}, {1'b1, 32'hA0000003}};
    spr_bcast_grant = 0;
    idx = 0;
    for (int k = 0; k < 7; k++) begin
      if (k == 4) spr_bcast_grant = 1;
      spr_output_valid = (idx < 3);
      spr_result = sv[idx % 3];
      spr_rs_id_out = RW'(idx + 1);
      spr_result_reg_addr_out = 10'(10'h3A0 + idx);
      #1;
      check("spr_bp_ready", 64'(spr_output_ready), 64'(bp_rdy[k]));
      acc = spr_output_valid && spr_output_ready;
      cycle();
      if (acc) idx++;
      check("spr_bp_out", 64'({update_spr_op_valid, update_spr_op_value_in}), 64'(bp_out[k]));
    end
    spr_output_valid = 0;
    #1;
    check("spr_bp_ready_back", 64'(spr_output_ready), 64'(1));

    // CR field table.
    cr_bcast_grant = 1;
    foreach (tbl[n]) begin
      cr_output_valid = 1; cr_result = tbl[n].cr; cr_result_enable = tbl[n].en; cr_rs_id_out = tbl[n].id;
      for (int k = 1; k <= LAT + 1; k++) begin
        cycle();
        if (k == 1) cr_output_valid = 0;
        check("cr_tbl_strobe", 64'(update_cr_op_valid), 64'(k == LAT ? tbl[n].ev : 8'h00));
        if (k == LAT) begin
          check("cr_tbl_value", 64'(update_cr_op_value_in), 64'(tbl[n].evals));
          check("cr_tbl_id", 64'(update_cr_op_rs_id_in), 64'({8{tbl[n].id}}));
        end
      end
    end

    // All three channels at once; SPR grant withheld so its strobe moves by 4.
    gpr_output_valid = 1; spr_output_valid = 1; cr_output_valid = 1;
    gpr_result = 32'h0000AAAA; spr_result = 32'h0000BBBB; cr_result = 32'h0000CCCC;
    cr_result_enable = 8'hFF;
    gpr_bcast_grant = 1; cr_bcast_grant = 1;
    t_g = -1; t_s = -1; t_c = -1;
    for (int k = 0; k < 10; k++) begin
      spr_bcast_grant = (k >= LAT + 3);
      cycle();
      if (k == 0) begin gpr_output_valid = 0; spr_output_valid = 0; cr_output_valid = 0; end
      if (update_gpr_op_valid && t_g < 0) t_g = k + 1;
      if (update_spr_op_valid && t_s < 0) t_s = k + 1;
      if (update_cr_op_valid != 0 && t_c < 0) t_c = k + 1;
    end
    check("conc_gpr_cycle", 64'(t_g), 64'(LAT));
    check("conc_cr_cycle", 64'(t_c), 64'(LAT));
    check("conc_spr_cycle", 64'(t_s), 64'(LAT + 4));

    // Ten back-to-back GPR results under random grant: order, no loss, no duplicate.
    foreach (gv[i]) gv[i] = $urandom;
    idx = 0; cyc = 0;
    while ((obs.size() < 10 || idx < 10) && cyc < 200) begin
      gpr_bcast_grant = 1'($urandom_range(0, 1));
      gpr_output_valid = (idx < 10);
      gpr_result = gv[idx % 10];
      gpr_result_reg_addr_out = 5'(idx);
      #1;
      acc = gpr_output_valid && gpr_output_ready;
      cycle();
      if (acc) idx++;
      if (update_gpr_op_valid) obs.push_back(update_gpr_op_value_in);
      cyc++;
    end
    gpr_output_valid = 0;
    check("wrap_count", 64'(obs.size()), 64'(10));
    foreach (obs[i]) if (i < 10) check($sformatf("wrap_order_%0d", i), 64'(obs[i]), 64'(gv[i]));

    // Reset with two GPR entries buffered: nothing may be broadcast afterwards.
    gpr_bcast_grant = 0;
    for (int k = 0; k < 2; k++) begin
      gpr_output_valid = 1; gpr_result = 32'h5A5A0000 + k;
      cycle();
    end
    gpr_output_valid = 0;
    check("midrst_req_before", 64'(gpr_bcast_req), 64'(1));
    apply_reset(1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("midrst_no_strobe", 64'(update_gpr_op_valid), 64'(0));
    end

    // Randomized traffic on all channels against the model.
    for (int k = 0; k < 400; k++) begin
      gpr_output_valid = 1'($urandom_range(0, 1));
      spr_output_valid = 1'($urandom_range(0, 1));
      cr_output_valid  = 1'($urandom_range(0, 1));
      gpr_bcast_grant  = 1'($urandom_range(0, 1));
      spr_bcast_grant  = 1'($urandom_range(0, 1));
      cr_bcast_grant   = 1'($urandom_range(0, 1));
      gpr_rs_id_out = RW'($urandom); spr_rs_id_out = RW'($urandom); cr_rs_id_out = RW'($urandom);
      gpr_result_reg_addr_out = 5'($urandom); spr_result_reg_addr_out = 10'($urandom);
      gpr_result = $urandom; spr_result = $urandom; cr_result = $urandom;
      cr_result_enable = 8'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
